csr_access_arbiter: RTL and testbench

Sequences and shares the single CSR register-file port between two requesters: the core pipeline (CSRRW/CSRRS/CSRRC execution) and the debug/management interface. Each granted access runs as an atomic read-then-optional-write. Set/clear values are computed from the value just read. The block sits between the requesters and the CSR file's csrRead*/csrWrite* port, whose csrReadData is combinational from csrReadAddress/csrReadEnable.

---
 rtl/csr_access_arbiter.sv | 176 +++++++++++++++++
 tb/tb_csr_access_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_arbiter.sv
// Shares the single CSR file port between the core pipeline and the debug interface.
// Each grant runs an atomic read-then-optional-write (CSRRW/CSRRS/CSRRC semantics).
module csr_access_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coreValid,
  input  logic [1:0]  coreOp,
  input  logic [11:0] coreAddress,
  input  logic [31:0] coreWriteData,
  output logic        coreDone,
  output logic        coreError,
  output logic [31:0] coreReadData,
  input  logic        debugValid,
  input  logic [1:0]  debugOp,
  input  logic [11:0] debugAddress,
  input  logic [31:0] debugWriteData,
  output logic        debugDone,
  output logic        debugError,
  output logic [31:0] debugReadData,
  output logic        csrReadEnable,
  output logic [11:0] csrReadAddress,
  input  logic [31:0] csrReadData,
  output logic        csrWriteEnable,
  output logic [11:0] csrWriteAddress,
  output logic [31:0] csrWriteData,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        owner_q;
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] old_q;
  logic        err_q;
  logic [3:0]  starve_q;
  logic [31:0] core_rd_q;
  logic [31:0] debug_rd_q;

  logic        req_any_s;
  logic        debug_win_s;
  logic        write_need_s;
  logic        read_only_s;
  logic [31:0] write_value_s;

  assign req_any_s    = coreValid | debugValid;
  assign debug_win_s  = debugValid & (~coreValid | (starve_q == LIMIT));
  assign write_need_s = (op_q == 2'b01) | (op_q[1] & (data_q != 32'h0000_0000));
  assign read_only_s  = (addr_q[11:10] == 2'b11);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = req_any_s ? S_READ : S_IDLE;
      S_READ:  state_d = (write_need_s && !read_only_s) ? S_WRITE : S_DONE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant latching, starvation counter, read capture and per-port result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= 1'b0;
      op_q       <= 2'b00;
      addr_q     <= 12'h000;
      data_q     <= 32'h0000_0000;
      old_q      <= 32'h0000_0000;
      err_q      <= 1'b0;
      starve_q   <= 4'd0;
      core_rd_q  <= 32'h0000_0000;
      debug_rd_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_any_s) begin
            owner_q <= debug_win_s;
            op_q    <= debug_win_s ? debugOp        : coreOp;
            addr_q  <= debug_win_s ? debugAddress   : coreAddress;
            data_q  <= debug_win_s ? debugWriteData : coreWriteData;
          end
          // The counter only grows while debug is actually waiting; it saturates at the limit.
          if (!debugValid || (req_any_s && debug_win_s)) begin
            starve_q <= 4'd0;
          end else if (req_any_s && (starve_q != LIMIT)) begin
            starve_q <= starve_q + 4'd1;
          end
        end
        S_READ: begin
          old_q <= csrReadData;
          err_q <= write_need_s & read_only_s;
          if (!(write_need_s && !read_only_s)) begin
            if (owner_q) debug_rd_q <= csrReadData;
            else         core_rd_q  <= csrReadData;
          end
        end
        S_WRITE: begin
          if (owner_q) debug_rd_q <= old_q;
          else         core_rd_q  <= old_q;
        end
        default: begin
        end
      endcase
    end
  end

  // Read-modify-write value for the CSR write port
  always_comb begin
    write_value_s = 32'h0000_0000;
    case (op_q)
      2'b01:   write_value_s = data_q;
      2'b10:   write_value_s = old_q | data_q;
      2'b11:   write_value_s = old_q & ~data_q;
      default: write_value_s = 32'h0000_0000;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    csrReadEnable   = 1'b0;
    csrReadAddress  = 12'h000;
    csrWriteEnable  = 1'b0;
    csrWriteAddress = 12'h000;
    csrWriteData    = 32'h0000_0000;
    coreDone        = 1'b0;
    debugDone       = 1'b0;
    coreError       = 1'b0;
    debugError      = 1'b0;
    busy            = (state_q != S_IDLE);
    case (state_q)
      S_READ: begin
        csrReadEnable  = 1'b1;
        csrReadAddress = addr_q;
      end
      S_WRITE: begin
        csrWriteEnable  = 1'b1;
        csrWriteAddress = addr_q;
        csrWriteData    = write_value_s;
      end
      S_DONE: begin
        coreDone   = ~owner_q;
        debugDone  = owner_q;
        coreError  = ~owner_q & err_q;
        debugError = owner_q & err_q;
      end
      default: begin
      end
    endcase
  end

  assign coreReadData  = core_rd_q;
  assign debugReadData = debug_rd_q;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Self-checking bench for csr_access_arbiter: directed scenarios plus randomized
// accesses scored against a CSR-semantics reference model.
module tb_csr_access_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        coreValid, debugValid;
  logic [1:0]  coreOp, debugOp;
  logic [11:0] coreAddress, debugAddress;
  logic [31:0] coreWriteData, debugWriteData;
  logic        coreDone, coreError, debugDone, debugError;
  logic [31:0] coreReadData, debugReadData;
  logic        csrReadEnable, csrWriteEnable, busy;
  logic [11:0] csrReadAddress, csrWriteAddress;
  logic [31:0] csrReadData, csrWriteData;

  logic [31:0] mem [0:4095];
  int passed = 0;
  int total  = 0;
  logic [31:0] exp_core_rd = 32'h0;
  logic [31:0] exp_dbg_rd  = 32'h0;

  csr_access_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .coreValid(coreValid), .coreOp(coreOp), .coreAddress(coreAddress),
    .coreWriteData(coreWriteData), .coreDone(coreDone), .coreError(coreError),
    .coreReadData(coreReadData),
    .debugValid(debugValid), .debugOp(debugOp), .debugAddress(debugAddress),
    .debugWriteData(debugWriteData), .debugDone(debugDone), .debugError(debugError),
    .debugReadData(debugReadData),
    .csrReadEnable(csrReadEnable), .csrReadAddress(csrReadAddress), .csrReadData(csrReadData),
    .csrWriteEnable(csrWriteEnable), .csrWriteAddress(csrWriteAddress),
    .csrWriteData(csrWriteData), .busy(busy)
  );

  // CSR file model: combinational read, write committed on the clock edge
  assign csrReadData = csrReadEnable ? mem[csrReadAddress] : 32'h0;
  always @(posedge clk) if (csrWriteEnable) mem[csrWriteAddress] <= csrWriteData;

  // Issue one request from IDLE and observe it until its Done (bounded).
  task automatic do_access(input bit dbg, input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] data, output int lat, output int rd_cyc,
                           output logic [31:0] rd, output logic err, output int nwr,
                           output logic [31:0] wdat, output logic [11:0] waddr,
                           output bit other_done);
    bit done;
    lat = 0; rd_cyc = 0; rd = 32'h0; err = 1'b0; nwr = 0; wdat = 32'h0; waddr = 12'h0;
    other_done = 1'b0; done = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 10 && busy; w++) @(negedge clk);
    if (dbg) begin
      debugValid = 1'b1; debugOp = op; debugAddress = addr; debugWriteData = data;
    end else begin
      coreValid = 1'b1; coreOp = op; coreAddress = addr; coreWriteData = data;
    end
    for (int c = 1; c <= 12 && !done; c++) begin
      @(posedge clk); #1;
      if (csrReadEnable && rd_cyc == 0) rd_cyc = c;
      if (csrWriteEnable) begin nwr++; wdat = csrWriteData; waddr = csrWriteAddress; end
      if (dbg ? coreDone : debugDone) other_done = 1'b1;
      if (dbg ? debugDone : coreDone) begin
        done = 1'b1; lat = c;
        rd  = dbg ? debugReadData : coreReadData;
        err = dbg ? debugError : coreError;
      end
    end
    if (dbg) debugValid = 1'b0; else coreValid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; coreValid = 1'b0; debugValid = 1'b0;
    coreOp = 2'b00; debugOp = 2'b00; coreAddress = 12'h0; debugAddress = 12'h0;
    coreWriteData = 32'h0; debugWriteData = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({busy, coreDone, debugDone, coreError, debugError, csrReadEnable, csrWriteEnable} !== 7'b0)
      $display("FAIL reset_ctrl: got %b expected 0", {busy, coreDone, debugDone, coreError, debugError, csrReadEnable, csrWriteEnable}); else passed++;
    total++; if ({coreReadData, debugReadData, csrWriteData} !== 96'h0)
      $display("FAIL reset_data: got %h expected 0", {coreReadData, debugReadData, csrWriteData}); else passed++;
    total++; if ({csrReadAddress, csrWriteAddress} !== 24'h0)
      $display("FAIL reset_addr: got %h expected 0", {csrReadAddress, csrWriteAddress}); else passed++;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_core_read();
    int lat, rc, nwr; logic [31:0] rd, wd; logic err; logic [11:0] wa; bit od;
    mem[12'hC00] <= 32'h0000_1234;
    do_access(1'b0, 2'b00, 12'hC00, 32'hFFFF_FFFF, lat, rc, rd, err, nwr, wd, wa, od);
    exp_core_rd = 32'h0000_1234;
    total++; if (rc !== 1) $display("FAIL read_cycle: got %0d expected 1", rc); else passed++;
    total++; if (lat !== 2) $display("FAIL read_latency: got %0d expected 2", lat); else passed++;
    total++; if (rd !== 32'h0000_1234) $display("FAIL read_data: got %h expected 00001234", rd); else passed++;
    total++; if (nwr !== 0 || err !== 1'b0) $display("FAIL read_nowrite: got writes=%0d err=%b expected 0 0", nwr, err); else passed++;
  endtask

  task automatic test_set_clear();
    int lat, rc, nwr; logic [31:0] rd, wd; logic err; logic [11:0] wa; bit od;
    mem[12'h340] <= 32'h0000_000F;
    do_access(1'b0, 2'b10, 12'h340, 32'h0000_00F0, lat, rc, rd, err, nwr, wd, wa, od);
    total++; if (nwr !== 1 || wd !== 32'h0000_00FF || wa !== 12'h340)
      $display("FAIL set_write: got n=%0d data=%h addr=%h expected 1 000000ff 340", nwr, wd, wa); else passed++;
    total++; if (lat !== 3 || rd !== 32'h0000_000F)
      $display("FAIL set_done: got lat=%0d rd=%h expected 3 0000000f", lat, rd); else passed++;
    mem[12'h340] <= 32'h0000_000F;
    do_access(1'b0, 2'b11, 12'h340, 32'h0000_0003, lat, rc, rd, err, nwr, wd, wa, od);
    exp_core_rd = 32'h0000_000F;
    total++; if (nwr !== 1 || wd !== 32'h0000_000C)
      $display("FAIL clear_write: got n=%0d data=%h expected 1 0000000c", nwr, wd); else passed++;
    total++; if (mem[12'h340] !== 32'h0000_000C) $display("FAIL clear_mem: got %h expected 0000000c", mem[12'h340]); else passed++;
  endtask

  task automatic test_readonly();
    int lat, rc, nwr; logic [31:0] rd, wd; logic err; logic [11:0] wa; bit od;
    mem[12'hF14] <= 32'hDEAD_BEEF;
    do_access(1'b1, 2'b01, 12'hF14, 32'h0000_0055, lat, rc, rd, err, nwr, wd, wa, od);
    exp_dbg_rd = 32'hDEAD_BEEF;
    total++; if (nwr !== 0 || lat !== 2) $display("FAIL ro_nowrite: got n=%0d lat=%0d expected 0 2", nwr, lat); else passed++;
    total++; if (err !== 1'b1 || rd !== 32'hDEAD_BEEF) $display("FAIL ro_error: got err=%b rd=%h expected 1 deadbeef", err, rd); else passed++;
    total++; if (coreReadData !== exp_core_rd) $display("FAIL ro_core_untouched: got %h expected %h", coreReadData, exp_core_rd); else passed++;
    do_access(1'b1, 2'b10, 12'hF14, 32'h0, lat, rc, rd, err, nwr, wd, wa, od);
    total++; if (err !== 1'b0 || lat !== 2 || nwr !== 0)
      $display("FAIL ro_set0: got err=%b lat=%0d n=%0d expected 0 2 0", err, lat, nwr); else passed++;
  endtask

  task automatic test_set_zero();
    int lat, rc, nwr; logic [31:0] rd, wd; logic err; logic [11:0] wa; bit od;
    mem[12'h300] <= 32'h0000_1800;
    do_access(1'b0, 2'b10, 12'h300, 32'h0, lat, rc, rd, err, nwr, wd, wa, od);
    exp_core_rd = 32'h0000_1800;
    total++; if (nwr !== 0 || lat !== 2 || rd !== 32'h0000_1800)
      $display("FAIL set_zero: got n=%0d lat=%0d rd=%h expected 0 2 00001800", nwr, lat, rd); else passed++;
  endtask

  task automatic test_random();
    int lat, rc, nwr, exp_lat; logic [31:0] rd, wd, old, data, newv; logic err; logic [11:0] wa, addr;
    logic [1:0] op; bit od, dbg, need, ro;
    for (int i = 0; i < 40; i++) begin
      dbg  = 1'($urandom_range(0, 1));
      op   = 2'($urandom_range(0, 3));
      addr = 12'($urandom_range(0, 4095));
      data = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      old  = $urandom;
      mem[addr] <= old;
      need = (op == 2'b01) || (op[1] && data != 32'h0);
      ro   = (addr[11:10] == 2'b11);
      case (op)
        2'b01:   newv = data;
        2'b10:   newv = old | data;
        2'b11:   newv = old & ~data;
        default: newv = old;
      endcase
      if (!need || ro) newv = old;
      exp_lat = (need && !ro) ? 3 : 2;
      do_access(dbg, op, addr, data, lat, rc, rd, err, nwr, wd, wa, od);
      if (dbg) exp_dbg_rd = old; else exp_core_rd = old;
      total++; if (lat !== exp_lat || rd !== old || err !== (need && ro))
        $display("FAIL rand%0d_result: got lat=%0d rd=%h err=%b expected %0d %h %b", i, lat, rd, err, exp_lat, old, need && ro); else passed++;
      total++; if (nwr !== ((need && !ro) ? 1 : 0) || mem[addr] !== newv)
        $display("FAIL rand%0d_write: got n=%0d mem=%h expected %0d %h", i, nwr, mem[addr], (need && !ro) ? 1 : 0, newv); else passed++;
      total++; if (od || coreReadData !== exp_core_rd || debugReadData !== exp_dbg_rd)
        $display("FAIL rand%0d_ports: got other=%b core=%h dbg=%h expected 0 %h %h", i, od, coreReadData, debugReadData, exp_core_rd, exp_dbg_rd); else passed++;
    end
  endtask

  task automatic test_starvation();
    int s, ng, cyc, last;
    bit exp_dbg, got_dbg;
    mem[12'h100] <= 32'h0000_0001;
    mem[12'h200] <= 32'h0000_0002;
    @(negedge clk);
    for (int w = 0; w < 10 && busy; w++) @(negedge clk);
    coreValid = 1'b1; coreOp = 2'b00; coreAddress = 12'h100; coreWriteData = 32'h0;
    debugValid = 1'b1; debugOp = 2'b00; debugAddress = 12'h200; debugWriteData = 32'h0;
    s = 0; ng = 0; last = -1;
    for (cyc = 1; cyc <= 80 && ng < 10; cyc++) begin
      @(posedge clk); #1;
      if (coreDone || debugDone) begin
        exp_dbg = (s == LIMIT);
        s = exp_dbg ? 0 : s + 1;
        got_dbg = debugDone;
        total++; if (got_dbg !== exp_dbg || (coreDone && debugDone))
          $display("FAIL grant%0d_owner: got debug=%b expected %b", ng, got_dbg, exp_dbg); else passed++;
        if (last >= 0) begin
          total++; if (cyc - last !== 3) $display("FAIL grant%0d_spacing: got %0d expected 3", ng, cyc - last); else passed++;
        end
        last = cyc; ng++;
      end
    end
    total++; if (ng !== 10) $display("FAIL starve_grants: got %0d expected 10", ng); else passed++;
    coreValid = 1'b0; debugValid = 1'b0;
    exp_core_rd = 32'h0000_0001; exp_dbg_rd = 32'h0000_0002;
  endtask

  task automatic test_reset_mid_write();
    bit saw, done; int lat;
    mem[12'h305] <= 32'h0000_00A0;
    @(negedge clk);
    for (int w = 0; w < 10 && busy; w++) @(negedge clk);
    coreValid = 1'b1; coreOp = 2'b10; coreAddress = 12'h305; coreWriteData = 32'h0000_000F;
    saw = 1'b0;
    for (int c = 0; c < 10 && !saw; c++) begin
      @(posedge clk); #1;
      if (csrWriteEnable) saw = 1'b1;
    end
    total++; if (!saw) $display("FAIL midrst_reach_write: got 0 expected 1"); else passed++;
    #1; rst = 1'b0; #1;
    total++; if ({busy, coreDone, csrWriteEnable, csrReadEnable, coreError} !== 5'b0 || {csrWriteData, csrWriteAddress, coreReadData} !== 76'h0)
      $display("FAIL midrst_async: got ctrl=%b data=%h expected 0 0", {busy, coreDone, csrWriteEnable, csrReadEnable, coreError}, {csrWriteData, csrWriteAddress, coreReadData}); else passed++;
    done = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (coreDone || debugDone) done = 1'b1; end
    total++; if (done) $display("FAIL midrst_nodone: got 1 expected 0"); else passed++;
    @(negedge clk); rst = 1'b1;
    done = 1'b0; lat = 0;
    for (int c = 1; c <= 12 && !done; c++) begin
      @(posedge clk); #1;
      if (coreDone) begin done = 1'b1; lat = c; end
    end
    total++; if (lat !== 3 || coreReadData !== 32'h0000_00A0)
      $display("FAIL midrst_regrant: got lat=%0d rd=%h expected 3 000000a0", lat, coreReadData); else passed++;
    coreValid = 1'b0;
    @(posedge clk); #1;
    total++; if (mem[12'h305] !== 32'h0000_00AF) $display("FAIL midrst_mem: got %h expected 000000af", mem[12'h305]); else passed++;
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_set_clear();
    test_readonly();
    test_set_zero();
    test_random();
    test_starvation();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
